// File: rtl/core_ifetch_pf.sv
// Instruction prefetcher: issues in-order AXI read requests ahead of the consumer and
// buffers the returned words with their PCs in a show-ahead FIFO; supports flush/redirect.
module core_ifetch_pf #(
    parameter logic [31:0] PC_INIT    = 32'h0,
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
    output logic                  AXI_ARVALID,
    input  logic                  AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
    input  logic [1:0]            AXI_RRESP,
    input  logic                  AXI_RVALID,
    output logic                  AXI_RREADY,
    output logic                  INSTR_VALID,
    output logic [31:0]           INSTRUCTION,
    output logic [31:0]           INSTR_PC,
    output logic                  INSTR_ERR,
    input  logic                  INSTR_READY,
    input  logic                  C_REDIRECT,
    input  logic [31:0]           REDIRECT_PC
);

    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;

    logic [31:0]   r_fpc;
    logic [31:0]   r_araddr;
    logic          r_arvalid;
    logic          r_stale;
    logic          r_rready;
    logic          r_halted;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_qwptr;
    logic [PW-1:0] r_qrptr;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_pc   [FIFO_DEPTH];
    logic          r_err  [FIFO_DEPTH];
    logic [31:0]   r_aq   [FIFO_DEPTH];

    logic           w_ar_hs;
    logic           w_r_hs;
    logic           w_drop;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;
    logic           w_r_err;
    logic           w_hold;
    logic           w_issue;
    logic           w_aq_push;
    logic [31:0]    w_fpc_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic [CW-1:0]  w_out_nxt;
    logic [CW-1:0]  w_discard_nxt;
    logic           w_halted_nxt;
    logic [CW1-1:0] w_credit;

    assign w_ar_hs   = r_arvalid & AXI_ARREADY;
    assign w_r_hs    = AXI_RVALID & r_rready;
    assign w_drop    = w_r_hs & (r_discard != '0);
    assign w_push    = w_r_hs & (r_discard == '0) & ~C_REDIRECT;
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & INSTR_READY & ~C_REDIRECT;
    assign w_r_err   = (AXI_RRESP != 2'b00);
    assign w_hold    = r_arvalid & ~AXI_ARREADY;
    // A request that was pending at redirect belongs to the old stream: no PC advance, no queue entry
    assign w_aq_push = w_ar_hs & ~r_stale & ~C_REDIRECT;
    assign w_fpc_nxt = r_fpc + ((w_ar_hs & ~r_stale) ? 32'd4 : 32'd0);

    always_comb begin
        w_count_nxt   = r_count;
        w_out_nxt     = r_out + CW'(w_ar_hs) - CW'(w_r_hs);
        w_discard_nxt = r_discard;
        w_halted_nxt  = r_halted | (w_push & w_r_err);
        if (C_REDIRECT) begin
            w_count_nxt   = '0;
            // Everything still outstanding after this cycle, including a held AR, gets dropped
            w_discard_nxt = r_out + CW'(r_arvalid) - CW'(w_r_hs);
            w_halted_nxt  = 1'b0;
        end else begin
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - CW'(1);
            end
            if (w_drop) begin
                w_discard_nxt = r_discard - CW'(1);
            end
        end
        w_credit = CW1'(w_count_nxt) + CW1'(w_out_nxt);
        w_issue  = ~C_REDIRECT & ~w_halted_nxt & (w_discard_nxt == '0)
                 & (w_credit < CW1'(FIFO_DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fpc     <= PC_INIT;
            r_araddr  <= PC_INIT;
            r_arvalid <= 1'b0;
            r_stale   <= 1'b0;
            r_rready  <= 1'b0;
            r_halted  <= 1'b0;
            r_count   <= '0;
            r_out     <= '0;
            r_discard <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_qwptr   <= '0;
            r_qrptr   <= '0;
        end else begin
            r_rready  <= 1'b1;
            r_count   <= w_count_nxt;
            r_out     <= w_out_nxt;
            r_discard <= w_discard_nxt;
            r_halted  <= w_halted_nxt;
            r_fpc     <= C_REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : w_fpc_nxt;
            if (w_hold) begin
                r_stale <= r_stale | C_REDIRECT;
            end else begin
                r_stale   <= 1'b0;
                r_arvalid <= w_issue;
                if (w_issue) begin
                    r_araddr <= w_fpc_nxt;
                end
            end
            if (C_REDIRECT) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_qwptr <= '0;
                r_qrptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr  <= r_wptr + PW'(1);
                    r_qrptr <= r_qrptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_aq_push) begin
                    r_qwptr <= r_qwptr + PW'(1);
                end
            end
        end
    end

    // Storage arrays need no reset: visibility is qualified by the counters
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_data[r_wptr] <= AXI_RDATA[31:0];
            r_pc[r_wptr]   <= r_aq[r_qrptr];
            r_err[r_wptr]  <= w_r_err;
        end
        if (!RST && w_aq_push) begin
            r_aq[r_qwptr] <= r_araddr;
        end
    end

    assign AXI_ARADDR  = r_araddr[AXI_AWIDTH-1:0];
    assign AXI_ARVALID = r_arvalid;
    assign AXI_RREADY  = r_rready;
    assign INSTR_VALID = w_valid;
    assign INSTRUCTION = w_valid ? r_data[r_rptr] : 32'd0;
    assign INSTR_PC    = w_valid ? r_pc[r_rptr] : 32'd0;
    assign INSTR_ERR   = w_valid ? r_err[r_rptr] : 1'b0;

endmodule

// File: tb/tb_core_ifetch_pf.sv
// Directed bench for core_ifetch_pf: streaming, backpressure, redirect, error halt,
// PC wrap and reset mid-stream, with an in-order AXI read responder.
module tb_core_ifetch_pf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_err;
    logic        instr_ready;
    logic        c_redirect;
    logic [31:0] redirect_pc;

    logic [31:0] w2_araddr;
    logic        w2_arvalid;
    logic        w2_arready;
    logic        w2_rready;
    logic        w2_ivalid;
    logic [31:0] w2_instr;
    logic [31:0] w2_ipc;
    logic        w2_ierr;

    int checks   = 0;
    int failures = 0;

    bit          rsp_en;
    logic [31:0] err_addr;
    logic [31:0] q[$];
    logic [31:0] ar_log[$];
    int          ar_cnt;
    int          r_cnt;

    always #5 clk = ~clk;

    core_ifetch_pf #(.PC_INIT(32'h0)) u_dut (
        .CLK(clk), .RST(rst),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .INSTR_VALID(instr_valid), .INSTRUCTION(instruction), .INSTR_PC(instr_pc),
        .INSTR_ERR(instr_err), .INSTR_READY(instr_ready),
        .C_REDIRECT(c_redirect), .REDIRECT_PC(redirect_pc)
    );

    core_ifetch_pf #(.PC_INIT(32'hFFFF_FFF8)) u_wrap (
        .CLK(clk), .RST(rst),
        .AXI_ARADDR(w2_araddr), .AXI_ARVALID(w2_arvalid), .AXI_ARREADY(w2_arready),
        .AXI_RDATA(32'd0), .AXI_RRESP(2'b00), .AXI_RVALID(1'b0), .AXI_RREADY(w2_rready),
        .INSTR_VALID(w2_ivalid), .INSTRUCTION(w2_instr), .INSTR_PC(w2_ipc),
        .INSTR_ERR(w2_ierr), .INSTR_READY(1'b0),
        .C_REDIRECT(1'b0), .REDIRECT_PC(32'd0)
    );

    // In-order read responder: data = address ^ CAFE0000, one beat per cycle when enabled
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            ar_log.delete();
            ar_cnt = 0;
            r_cnt  = 0;
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= 2'b00;
        end else begin
            if (rvalid && rready) begin
                void'(q.pop_front());
                r_cnt++;
            end
            if (arvalid && arready) begin
                q.push_back(araddr);
                ar_log.push_back(araddr);
                ar_cnt++;
            end
            if (rsp_en && q.size() != 0) begin
                rvalid <= 1'b1;
                rdata  <= q[0] ^ 32'hCAFE_0000;
                rresp  <= (q[0] == err_addr) ? 2'b10 : 2'b00;
            end else begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; arready = 1'b0; instr_ready = 1'b0; c_redirect = 1'b0;
        redirect_pc = 32'd0; rsp_en = 1'b0; err_addr = 32'hFFFF_FFF0; w2_arready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_ivalid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_ierr", 32'(instr_err), 32'd0);

        // Zero-wait streaming, plus the wrap instance running alongside
        arready = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1; rst = 1'b0;
        @(negedge clk);
        chk("first_arvalid", 32'(arvalid), 32'd1);
        chk("first_araddr", araddr, 32'd0);
        chk("wrap_addr0", w2_araddr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_addr1", w2_araddr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr2", w2_araddr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc", instr_pc, 32'(i * 4));
            chk("stream_data", instruction, 32'hCAFE_0000 ^ 32'(i * 4));
            @(negedge clk);
        end

        // Reset while a request is in flight
        chk("pre_reset_arvalid", 32'(arvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_rready", 32'(rready), 32'd0);
        chk("midrst_ivalid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instruction, 32'd0);
        chk("midrst_ipc", instr_pc, 32'd0);
        chk("midrst_ierr", 32'(instr_err), 32'd0);

        // Backpressure: buffer plus in-flight credit caps the request count
        instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arvalid", 32'(arvalid), 32'd1);
        chk("rel_araddr", araddr, 32'd0);
        repeat (8) @(negedge clk);
        chk("bp_ar_cnt", 32'(ar_cnt), 32'd4);
        chk("bp_arvalid", 32'(arvalid), 32'd0);
        chk("bp_head_pc", instr_pc, 32'd0);
        pop_one();
        repeat (6) @(negedge clk);
        chk("bp_ar_cnt_pop", 32'(ar_cnt), 32'd5);
        chk("bp_arvalid_pop", 32'(arvalid), 32'd0);
        chk("bp_head_pc_pop", instr_pc, 32'd4);
        chk("bp_new_addr", ar_log[4], 32'd16);

        // Redirect with two responses outstanding and one request held
        rst = 1'b1; arready = 1'b0; rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rd_ar0", araddr, 32'd0);
        arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        arready = 1'b0;
        chk("rd_pending_addr", araddr, 32'd8);
        chk("rd_pending_valid", 32'(arvalid), 32'd1);
        c_redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        c_redirect = 1'b0;
        chk("rd_held_valid", 32'(arvalid), 32'd1);
        chk("rd_held_addr", araddr, 32'd8);
        chk("rd_flushed", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rd_held_addr2", araddr, 32'd8);
        arready = 1'b1; rsp_en = 1'b1;
        n = 0;
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rd_valid_timeout", 32'(instr_valid), 32'd1);
        chk("rd_first_pc", instr_pc, 32'h100);
        chk("rd_first_data", instruction, 32'hCAFE_0100);
        chk("rd_r_beats", 32'(r_cnt), 32'd4);
        chk("rd_stale_addr", ar_log[2], 32'd8);
        chk("rd_new_addr", ar_log[3], 32'h100);

        // Error response halts further requests until redirect
        rst = 1'b1; arready = 1'b1; rsp_en = 1'b1; err_addr = 32'd8;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("err_ar_cnt", 32'(ar_cnt), 32'd4);
        chk("err_head_pc0", instr_pc, 32'd0);
        chk("err_head_err0", 32'(instr_err), 32'd0);
        pop_one();
        chk("err_head_pc4", instr_pc, 32'd4);
        pop_one();
        chk("err_head_pc8", instr_pc, 32'd8);
        chk("err_head_err8", 32'(instr_err), 32'd1);
        chk("err_head_data8", instruction, 32'hCAFE_0008);
        repeat (4) @(negedge clk);
        chk("err_halt_ar_cnt", 32'(ar_cnt), 32'd4);
        chk("err_halt_arvalid", 32'(arvalid), 32'd0);
        pop_one();
        chk("err_pc12", instr_pc, 32'd12);
        chk("err_err12", 32'(instr_err), 32'd0);
        c_redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        c_redirect = 1'b0;
        chk("err_redir_flush", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("err_redir_arvalid", 32'(arvalid), 32'd1);
        chk("err_redir_araddr", araddr, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_ifetch_pf.md
CORE_IFETCH_PF -- requirements
Module: core_ifetch_pf

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter AXI_AWIDTH, default 32, meaning the AXI read address width; addresses are truncated to this width.
REQ-003 The block SHALL have parameter AXI_DWIDTH, default 32, meaning the AXI read data width; only 32 is supported.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of prefetch buffer entries; it must be a power of 2 and at least 2.
REQ-005 The block SHALL have the following ports, with one clock and a synchronous, active-high reset:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- AXI_ARADDR  out  AXI_AWIDTH  read address.
- AXI_ARVALID  out  1  read address valid.
- AXI_ARREADY  in  1  read address ready.
- AXI_RDATA  in  AXI_DWIDTH  read data.
- AXI_RRESP  in  2  read response.
- AXI_RVALID  in  1  read data valid.
- AXI_RREADY  out  1  read data ready.
- INSTR_VALID  out  1  head buffer entry valid.
- INSTRUCTION  out  32  head instruction word.
- INSTR_PC  out  32  address of the head instruction.
- INSTR_ERR  out  1  head entry came from a response with RRESP!=0.
- INSTR_READY  in  1  consumer pops the head entry when INSTR_VALID=1.
- C_REDIRECT  in  1  flush and restart fetch.
- REDIRECT_PC  in  32  absolute restart address.

Function
REQ-006 The block SHALL keep a fetch PC (FPC) and SHALL increment it by 4 on each AR handshake (ARVALID&ARREADY), wrapping modulo 2^32.
REQ-007 AXI_ARADDR SHALL equal the registered request address bits [AXI_AWIDTH-1:0].
REQ-008 The block SHALL assert a new AR only when not halted and fifo_count+inflight < FIFO_DEPTH, where inflight counts ARs accepted or pending whose R has not yet returned.
REQ-009 Once ARVALID=1, ARVALID and ARADDR SHALL hold stable until ARREADY=1; a back-to-back AR SHALL be allowed in the cycle after a handshake.
REQ-010 AXI_RREADY SHALL be 1 in every cycle after reset deasserts; credit accounting guarantees buffer space.
REQ-011 An accepted R beat (RVALID&RREADY) that is not being discarded SHALL write {RDATA, its request address, RRESP!=0} into the FIFO, visible at INSTR_VALID/INSTRUCTION/INSTR_PC/INSTR_ERR in the following cycle (1-cycle latency, show-ahead FIFO).
REQ-012 A push and a pop in the same cycle SHALL leave the count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 The request address of each entry SHALL be tracked in request order via an address queue of FIFO_DEPTH entries; AXI responses are in order.
REQ-014 A push with ERR=1 SHALL set halted; while halted, no new AR is issued, while pending ARs and Rs complete normally.
REQ-015 On C_REDIRECT=1, the block SHALL, at the next edge:
- empty the FIFO and the address queue;
- set FPC to {REDIRECT_PC[31:2],2'b00};
- clear halted;
- set discard to the number of outstanding responses after this cycle, including a pending unaccepted AR.
REQ-016 While discard>0, each R beat SHALL decrement discard and SHALL NOT be pushed; no new AR SHALL issue until discard=0 and no AR is pending.
REQ-017 A pending AR at redirect SHALL NOT be dropped; it SHALL complete with its original address, and its response SHALL be discarded.
REQ-018 Redirect SHALL take priority over a simultaneous pop, push, or R beat; an R beat in the redirect cycle SHALL itself be discarded and not counted in discard.
REQ-019 A redirect while discard>0 SHALL add the newly outstanding count to the remaining discard.

Reset
REQ-020 While RST=1, the block SHALL drive AXI_ARVALID=0, AXI_RREADY=0, INSTR_VALID=0, INSTRUCTION=0, INSTR_PC=0, and INSTR_ERR=0, and SHALL hold FPC=PC_INIT, counts=0, discard=0, and halted=0.
REQ-021 Reset mid-transaction SHALL abandon all state immediately; this is valid only under system-wide reset.
REQ-022 The first AR SHALL assert in the first cycle after RST falls, with ARADDR=PC_INIT.

Verification
REQ-023 The bench SHALL cover zero-wait streaming: ARREADY=1, RVALID 1 cycle after AR, INSTR_READY=1 -> PCs 0,4,8,12 appear in order, one per cycle, with no bubbles after fill.
REQ-024 The bench SHALL cover backpressure: INSTR_READY=0 -> exactly 4 ARs (FIFO_DEPTH=4), then ARVALID stays 0; one pop -> exactly one new AR.
REQ-025 The bench SHALL cover redirect with traffic in flight: 2 Rs outstanding and ARVALID pending with ARREADY=0, then C_REDIRECT with REDIRECT_PC=0x103 -> ARADDR is held until accepted, 3 Rs are discarded, and the next AR has ARADDR=0x100 with the first INSTR_PC=0x100.
REQ-026 The bench SHALL cover an error response: RRESP=2'b10 at PC 0x8 -> entry with INSTR_ERR=1 and INSTR_PC=0x8, with no further ARs until redirect.
REQ-027 The bench SHALL cover wrap-around: PC_INIT=0xFFFFFFF8 -> ARADDRs 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-028 The bench SHALL cover reset mid-stream: RST asserted with ARVALID=1 -> outputs take reset values next edge, and the first AR after release has ARADDR=PC_INIT.
